// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, decoder states and event layout for the PS/2 keyboard receiver
package ps2_pkg;
  localparam logic [7:0] PS2_E0 = 8'hE0;
  localparam logic [7:0] PS2_F0 = 8'hF0;
  localparam int FRAME_BITS = 11;
  localparam int EV_W = 10;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_E0   = 2'd1,
    ST_F0   = 2'd2,
    ST_E0F0 = 2'd3
  } ps2_state_t;
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } ps2_ev_t;
endpackage

// File: rtl/ps2_scan2ascii.sv
// ps2_scan2ascii: set-2 scan code to ASCII for letters, digits, space and enter
module ps2_scan2ascii (
  input  logic [7:0] code_i,
  input  logic       ext_i,
  output logic [7:0] ascii_o
);
  logic [7:0] a;
  always_comb begin
    a = 8'h00;
    case (code_i)
      8'h1C: a = "a"; 8'h32: a = "b"; 8'h21: a = "c"; 8'h23: a = "d";
      8'h24: a = "e"; 8'h2B: a = "f"; 8'h34: a = "g"; 8'h33: a = "h";
      8'h43: a = "i"; 8'h3B: a = "j"; 8'h42: a = "k"; 8'h4B: a = "l";
      8'h3A: a = "m"; 8'h31: a = "n"; 8'h44: a = "o"; 8'h4D: a = "p";
      8'h15: a = "q"; 8'h2D: a = "r"; 8'h1B: a = "s"; 8'h2C: a = "t";
      8'h3C: a = "u"; 8'h2A: a = "v"; 8'h1D: a = "w"; 8'h22: a = "x";
      8'h35: a = "y"; 8'h1A: a = "z";
      8'h45: a = "0"; 8'h16: a = "1"; 8'h1E: a = "2"; 8'h26: a = "3";
      8'h25: a = "4"; 8'h2E: a = "5"; 8'h36: a = "6"; 8'h3D: a = "7";
      8'h3E: a = "8"; 8'h46: a = "9";
      8'h29: a = " "; 8'h5A: a = 8'h0D;
      default: a = 8'h00;
    endcase
  end
  assign ascii_o = ext_i ? 8'h00 : a;
endmodule

// File: rtl/ps2_kbd_event_rx.sv
// ps2_kbd_event_rx: PS/2 set-2 receiver decoding E0/F0-prefixed key events into a show-ahead FIFO
module ps2_kbd_event_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          ev_ready,
  input  logic                          err_clr,
  output logic                          ev_valid,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_release,
  output logic [7:0]                    ev_ascii,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    press_count,
  output logic                          overflow,
  output logic                          frame_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sc_q, sd_q;
  logic [3:0]             cnt_q;
  logic [TW-1:0]          tmo_q;
  logic [FRAME_BITS-2:0]  sh_q;
  logic [FRAME_BITS-1:0]  frame;
  logic [7:0]             byte_q, pc_q;
  logic                   byte_v_q, ovf_q, ferr_q;
  logic                   strobe, last, good, tmo_hit, push, push_ok, pop, full;
  ps2_state_t             st_q, st_d;
  ps2_ev_t                ev_d, head;
  ps2_ev_t                mem_q [FIFO_DEPTH];
  logic [AW:0]            wr_q, rd_q, level;

  // Falling edge seen between the two oldest synchroniser stages
  assign strobe  = sc_q[SYNC_STAGES-1] & ~sc_q[SYNC_STAGES-2];
  assign frame   = {sd_q[SYNC_STAGES-1], sh_q};
  assign last    = strobe && cnt_q == 4'(FRAME_BITS - 1);
  assign good    = last && !frame[0] && frame[FRAME_BITS-1] && ^frame[FRAME_BITS-2:1];
  assign tmo_hit = !strobe && cnt_q != 4'd0 && tmo_q == TW'(TIMEOUT_CYCLES - 1);

  // Prefix bytes accumulate into the state bits: bit0 = extended, bit1 = release
  always_comb begin
    st_d = st_q;
    push = 1'b0;
    ev_d = '{code: byte_q, ext: st_q[0], rel: st_q[1]};
    if (byte_v_q) begin
      if (byte_q == PS2_E0) st_d = ps2_state_t'(st_q | 2'b01);
      else if (byte_q == PS2_F0) st_d = ps2_state_t'(st_q | 2'b10);
      else begin
        st_d = ST_IDLE;
        push = 1'b1;
      end
    end
  end

  assign level   = wr_q - rd_q;
  assign ev_valid = level != '0;
  assign full    = level == LW'(FIFO_DEPTH);
  assign pop     = ev_valid & ev_ready;
  assign push_ok = push & (~full | pop);
  assign head    = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!clrn) begin
      sc_q     <= '1;
      sd_q     <= '1;
      cnt_q    <= '0;
      tmo_q    <= '0;
      byte_v_q <= 1'b0;
      st_q     <= ST_IDLE;
      wr_q     <= '0;
      rd_q     <= '0;
      pc_q     <= '0;
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sc_q     <= {sc_q[SYNC_STAGES-2:0], ps2_clk};
      sd_q     <= {sd_q[SYNC_STAGES-2:0], ps2_data};
      if (strobe) begin
        cnt_q <= last ? 4'd0 : cnt_q + 4'd1;
        tmo_q <= '0;
      end else if (tmo_hit) begin
        cnt_q <= '0;
        tmo_q <= '0;
      end else tmo_q <= (cnt_q != 4'd0) ? tmo_q + TW'(1) : '0;
      byte_v_q <= good;
      st_q     <= st_d;
      if (push_ok) wr_q <= wr_q + LW'(1);
      if (pop) rd_q <= rd_q + LW'(1);
      if (push_ok && !ev_d.rel) pc_q <= pc_q + 8'd1;
      ovf_q    <= (push & full & ~pop) | (ovf_q & ~err_clr);
      ferr_q   <= (last & ~good) | tmo_hit | (ferr_q & ~err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (strobe) sh_q <= frame[FRAME_BITS-1:1];
    if (good) byte_q <= frame[8:1];
    if (push_ok) mem_q[wr_q[AW-1:0]] <= ev_d;
  end

  ps2_scan2ascii u_ascii (
    .code_i  (head.code),
    .ext_i   (head.ext),
    .ascii_o (ev_ascii)
  );

  assign ev_code     = head.code;
  assign ev_ext      = head.ext;
  assign ev_release  = head.rel;
  assign fifo_level  = level;
  assign press_count = pc_q;
  assign overflow    = ovf_q;
  assign frame_err   = ferr_q;
endmodule

// File: doc/ps2_kbd_event_rx.md
Name: ps2_kbd_event_rx

Overview:
Parametrised successor to the PS/2 keyboard receiver. Deserialises PS/2 set-2 frames and decodes the E0/F0 prefixes into complete key events (code, extended, release). Buffers events in a configurable-depth FIFO with a valid/ready output handshake. Adds frame timeout, sticky error flags, press counting and ASCII lookup; feeds display/console logic in place of the raw-byte receiver.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of two, at least 2.
SYNC_STAGES, 3, ps2_clk/ps2_data synchroniser depth; at least 2.
TIMEOUT_CYCLES, 50000, clk cycles without a ps2_clk falling edge before a partial frame is discarded.

Ports:
clk  in  1  system clock
clrn  in  1  synchronous active-low reset
ps2_clk  in  1  raw PS/2 clock, asynchronous
ps2_data  in  1  raw PS/2 data, asynchronous
ev_ready  in  1  consumer accepts head event
err_clr  in  1  clears overflow and frame_err
ev_valid  out  1  FIFO non-empty
ev_code  out  8  head event scan code (final byte)
ev_ext  out  1  head event had E0 prefix
ev_release  out  1  head event had F0 prefix
ev_ascii  out  8  ASCII of head event; 0 if unmapped
fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries
press_count  out  8  make events accepted, wraps
overflow  out  1  sticky, event dropped on full FIFO
frame_err  out  1  sticky, bad start/stop/parity or timeout

Behaviour:
- Reset is synchronous on clrn==0: FIFO pointers and level 0, ev_valid 0, press_count 0, overflow 0, frame_err 0, bit counter 0, timeout counter 0, decoder in IDLE. Synchroniser stages reset to 1 (line idle high) so no false edge is generated. Reset mid-frame discards the partial frame.
- Sampling: the sample strobe fires when the synchronised ps2_clk goes 1 to 0, as seen across the last two sync stages.
- Frame capture: an 11-bit frame (start, 8 data LSB first, odd parity, stop) is shifted on each strobe.
- On the 11th strobe (cycle T), the frame is accepted only if start==0, stop==1 and the XOR of data and parity is 1. An accepted byte is registered at the end of T. The bit counter returns to 0 either way.
- A bad frame sets frame_err. The byte is dropped and the decoder state is unchanged.
- Timeout: while the bit counter is non-zero, the timeout counter increments each clk and resets on every strobe. When it reaches TIMEOUT_CYCLES, the bit counter is cleared and frame_err is set.
- Decoder FSM: states IDLE, E0, F0, E0F0, advanced on each accepted byte during T+1.
  - IDLE: 0xE0 goes to E0; 0xF0 goes to F0; any other byte emits {code, ext=0, rel=0}.
  - E0: 0xF0 goes to E0F0; 0xE0 stays in E0; any other byte emits {code, 1, 0} and returns to IDLE.
  - F0: 0xE0 goes to E0F0; 0xF0 stays in F0; any other byte emits {code, 0, 1} and returns to IDLE.
  - E0F0: 0xE0/0xF0 stay in E0F0; any other byte emits {code, 1, 1} and returns to IDLE.
- Emit: the event is written to the FIFO at the end of T+1. ev_valid is high from T+2 (FIFO previously empty).
- Output: show-ahead. ev_code/ev_ext/ev_release always reflect the head entry while ev_valid=1. A pop occurs on any cycle with ev_valid and ev_ready both high.
- Full FIFO: a push with no pop is dropped and sets overflow. A push with a pop in the same cycle is accepted and the level is unchanged.
- Empty FIFO: ev_ready is ignored. A push into an empty FIFO is not visible until the next cycle.
- press_count increments on each accepted push with rel==0, wrapping 255 to 0. Dropped events are not counted.
- err_clr clears both sticky flags. If a set event occurs in the same cycle, set has priority.
- ev_ascii is combinational from the head entry:
  - Letters a-z use set-2 codes (0x1C→'a' ... 0x1A→'z').
  - Digits: 0x45→'0', 0x16→'1', 0x1E→'2', 0x26→'3', 0x25→'4', 0x2E→'5', 0x36→'6', 0x3D→'7', 0x3E→'8', 0x46→'9'.
  - 0x29→' ' and 0x5A→0x0D.
  - ext=1 or any other code gives 0.
  - Release events still report the key's ASCII.
- Pointer arithmetic wraps modulo FIFO_DEPTH. fifo_level is computed from pointers that are one bit wider than the address.

Decomposition:
- ps2_pkg holds:
  - constants PS2_E0=8'hE0, PS2_F0=8'hF0;
  - FRAME_BITS=11;
  - decoder state encoding (IDLE=0, E0=1, F0=2, E0F0=3);
  - event field widths (EV_W=10: code, ext, rel).
- Sub-module ps2_scan2ascii: purely combinational 8-bit code plus ext in, 8-bit ASCII out. It is reused by console logic.

Test Plan:
- Frame 0x1C (parity 0, stop 1) → at T+2 ev_valid=1, ev_code=0x1C, ev_ext=0, ev_release=0, ev_ascii=0x61, press_count=1.
- Frames F0,1C → one event {0x1C, 0, 1}, ev_ascii=0x61, press_count unchanged. Frames E0,F0,75 → one event {0x75, 1, 1}, ev_ascii=0.
- Frame 0x32 with wrong parity → frame_err=1, no event. Next valid 0x32 is delivered; after err_clr pulse, frame_err=0.
- Hold ev_ready=0 and send FIFO_DEPTH+1 make codes (0x16×9 for default 8) → fifo_level=8, overflow=1, press_count=8. Draining yields 8 events of 0x16/'1'.
- Full FIFO, ev_ready=1 in the same cycle a new event is written → level stays 8, overflow stays 0, order preserved.
- Drive 5 strobes, then idle TIMEOUT_CYCLES → frame_err=1. Next complete frame 0x1D is received correctly as 'w'. clrn low mid-frame → all outputs return to reset values.
